// File: rtl/sample_chunker.sv
// Ping-pong ADC sample packer: fills one bank of IO_BUFF_SIZE samples while the other is read.
// Optional macro SAMPLE_CHUNKER_CHUNK_COUNT_EN adds a 16-bit completed-chunk counter output.
module sample_chunker #(
  parameter int unsigned SAMPLE_SIZE      = 24,
  parameter int unsigned IO_BUFF_SIZE     = 64,
  parameter int unsigned IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE),
  parameter int unsigned DISCARD_COUNT    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        in_valid,
  input  logic [SAMPLE_SIZE-1:0]      in_sample,
  input  logic [IO_BUFF_PTR_BITS-1:0] rd_ptr,
  output logic [SAMPLE_SIZE-1:0]      rd_sample,
  output logic                        chunk_pulse,
  output logic                        rd_bank,
  output logic [IO_BUFF_PTR_BITS:0]   fill_level
`ifdef SAMPLE_CHUNKER_CHUNK_COUNT_EN
  ,
  output logic [15:0]                 chunk_count
`endif
);

  localparam int unsigned ADDR_W = IO_BUFF_PTR_BITS + 1;
  localparam int unsigned DEPTH  = 2 * IO_BUFF_SIZE;
  localparam int unsigned DISC_W = (DISCARD_COUNT > 1) ? $clog2(DISCARD_COUNT) : 1;
  localparam logic [IO_BUFF_PTR_BITS-1:0] LAST_PTR  = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);
  localparam logic [DISC_W-1:0]           DISC_LAST = DISC_W'(DISCARD_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DISCARD = 2'd1,
    ST_FILL    = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [IO_BUFF_PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [IO_BUFF_PTR_BITS:0]   fill_level_q, fill_level_d;
  logic [DISC_W-1:0]           disc_q, disc_d;
  logic                        fill_bank_q, fill_bank_d;
  logic                        rd_bank_q, rd_bank_d;
  logic                        chunk_pulse_q, chunk_pulse_d;
  logic [SAMPLE_SIZE-1:0]      rd_sample_q;
  logic                        mem_we_c;
  logic [ADDR_W-1:0]           wr_addr_c, rd_addr_c;
  logic [SAMPLE_SIZE-1:0]      mem_q [DEPTH];

  assign wr_addr_c = {fill_bank_q, wr_ptr_q};
  assign rd_addr_c = {rd_bank_q, rd_ptr};

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      fill_level_q  <= '0;
      disc_q        <= '0;
      fill_bank_q   <= 1'b0;
      rd_bank_q     <= 1'b1;
      chunk_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_level_q  <= fill_level_d;
      disc_q        <= disc_d;
      fill_bank_q   <= fill_bank_d;
      rd_bank_q     <= rd_bank_d;
      chunk_pulse_q <= chunk_pulse_d;
    end
  end

  // Next-state: discard warm-up samples, then pack into the fill bank
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    fill_level_d  = fill_level_q;
    disc_d        = disc_q;
    fill_bank_d   = fill_bank_q;
    rd_bank_d     = rd_bank_q;
    chunk_pulse_d = 1'b0;
    mem_we_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (DISCARD_COUNT == 0) state_d = ST_FILL;
          else                    state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (in_valid) begin
          if (disc_q == DISC_LAST) begin
            disc_d       = '0;
            wr_ptr_d     = '0;
            fill_level_d = '0;
            state_d      = ST_FILL;
          end else begin
            disc_d = disc_q + DISC_W'(1);
          end
        end
      end
      ST_FILL: begin
        if (in_valid) begin
          mem_we_c = 1'b1;
          // Last slot: hand the full bank to the reader in the same edge
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d      = '0;
            fill_level_d  = '0;
            fill_bank_d   = ~fill_bank_q;
            rd_bank_d     = fill_bank_q;
            chunk_pulse_d = 1'b1;
          end else begin
            wr_ptr_d     = wr_ptr_q + IO_BUFF_PTR_BITS'(1);
            fill_level_d = fill_level_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable abandons any partial bank; bank assignment is kept
    if (!enable) begin
      state_d      = ST_IDLE;
      wr_ptr_d     = '0;
      fill_level_d = '0;
      disc_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[wr_addr_c] <= in_sample;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_sample_q <= '0;
    else     rd_sample_q <= mem_q[rd_addr_c];
  end

`ifdef SAMPLE_CHUNKER_CHUNK_COUNT_EN
  logic [15:0] chunk_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                chunk_count_q <= '0;
    else if (chunk_pulse_q) chunk_count_q <= chunk_count_q + 16'd1;
  end

  assign chunk_count = chunk_count_q;
`endif

  assign rd_sample   = rd_sample_q;
  assign chunk_pulse = chunk_pulse_q;
  assign rd_bank     = rd_bank_q;
  assign fill_level  = fill_level_q;

endmodule

// File: tb/tb_sample_chunker.sv
// Self-checking bench for sample_chunker: vector table, reference model and read scoreboard.
module tb_sample_chunker;

  localparam int unsigned SW   = 24;
  localparam int unsigned N    = 64;
  localparam int unsigned PB   = 6;
  localparam int unsigned DISC = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          in_valid;
  logic [SW-1:0] in_sample;
  logic [PB-1:0] rd_ptr;
  logic [SW-1:0] rd_sample;
  logic          chunk_pulse;
  logic          rd_bank;
  logic [PB:0]   fill_level;
`ifdef SAMPLE_CHUNKER_CHUNK_COUNT_EN
  logic [15:0]   chunk_count;
`endif

  sample_chunker #(
    .SAMPLE_SIZE(SW), .IO_BUFF_SIZE(N), .IO_BUFF_PTR_BITS(PB), .DISCARD_COUNT(DISC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .in_sample(in_sample), .rd_ptr(rd_ptr), .rd_sample(rd_sample),
    .chunk_pulse(chunk_pulse), .rd_bank(rd_bank), .fill_level(fill_level)
`ifdef SAMPLE_CHUNKER_CHUNK_COUNT_EN
    , .chunk_count(chunk_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit            m_active;
  int            m_cnt;
  bit            m_fill_bank;
  bit            m_rd_bank;
  bit            m_pulse;
  int            m_chunks;
  logic [SW-1:0] m_mem   [2][N];
  bit            m_known [2][N];
  logic [SW-1:0] rd_q[$];
  logic [SW-1:0] next_val;

  typedef struct {
    bit en;
    bit v;
    int reps;
    int exp_fill;
    bit exp_pulse;
    bit exp_bank;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_fill();
    if (m_cnt <= int'(DISC)) return 0;
    return (m_cnt - int'(DISC)) % int'(N);
  endfunction

  task automatic model_reset();
    m_active    = 1'b0;
    m_cnt       = 0;
    m_fill_bank = 1'b0;
    m_rd_bank   = 1'b1;
    m_pulse     = 1'b0;
    m_chunks    = 0;
    rd_q.delete();
  endtask

  // One clock: drive inputs, advance the model, then compare just after the edge
  task automatic tick(input bit en, input bit v, input logic [SW-1:0] s,
                      input logic [PB-1:0] p, input bit rd);
    int k;
    bit did_rd;
    enable    = en;
    in_valid  = v;
    in_sample = s;
    rd_ptr    = p;
    did_rd    = rd && m_known[m_rd_bank][p];
    if (did_rd) rd_q.push_back(m_mem[m_rd_bank][p]);
    m_pulse = 1'b0;
    if (m_active && v) begin
      if (m_cnt >= int'(DISC)) begin
        k = (m_cnt - int'(DISC)) % int'(N);
        m_mem[m_fill_bank][k]   = s;
        m_known[m_fill_bank][k] = 1'b1;
        if (k == int'(N) - 1) begin
          m_rd_bank   = m_fill_bank;
          m_fill_bank = ~m_fill_bank;
          m_pulse     = 1'b1;
          m_chunks++;
        end
      end
      m_cnt++;
    end
    if (!en) begin
      m_active = 1'b0;
      m_cnt    = 0;
    end else begin
      m_active = 1'b1;
    end
    @(posedge clk);
    #1;
    check("chunk_pulse", 32'(chunk_pulse), 32'(m_pulse));
    check("rd_bank", 32'(rd_bank), 32'(m_rd_bank));
    check("fill_level", 32'(fill_level), 32'(exp_fill()));
    if (did_rd) check("rd_sample", 32'(rd_sample), 32'(rd_q.pop_front()));
`ifdef SAMPLE_CHUNKER_CHUNK_COUNT_EN
    check("chunk_count", 32'(chunk_count), 32'(m_chunks & 16'hFFFF));
`endif
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    rd_ptr    = '0;
    next_val  = '0;
    model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < int'(N); i++) m_known[b][i] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_pulse", 32'(chunk_pulse), 32'd0);
    check("reset_rd_bank", 32'(rd_bank), 32'd1);
    check("reset_fill", 32'(fill_level), 32'd0);
    check("reset_rd_sample", 32'(rd_sample), 32'd0);

    // First chunk: idle->discard, 16 discards, fill with a gap, complete at sample 79
    vt[0] = '{1, 0, 1,  0, 0, 1};
    vt[1] = '{1, 1, 16, 0, 0, 1};
    vt[2] = '{1, 1, 3,  3, 0, 1};
    vt[3] = '{1, 0, 2,  3, 0, 1};
    vt[4] = '{1, 1, 61, 0, 1, 0};
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < vt[r].reps; j++) begin
        tick(vt[r].en, vt[r].v, next_val, '0, 1'b0);
        if (vt[r].v) next_val = next_val + SW'(1);
      end
      check("vec_fill", 32'(fill_level), 32'(vt[r].exp_fill));
      check("vec_pulse", 32'(chunk_pulse), 32'(vt[r].exp_pulse));
      check("vec_bank", 32'(rd_bank), 32'(vt[r].exp_bank));
    end

    // Read sweep: one-cycle latency, bank 0 holds 16..79
    for (int p = 0; p < int'(N); p++) begin
      tick(1'b1, 1'b0, '0, PB'(p), 1'b1);
      check("sweep_val", 32'(rd_sample), 32'(16 + p));
    end

    // Back-to-back 80..143, then keep streaming 30 more across the bank switch
    for (int i = 0; i < int'(N); i++) begin
      tick(1'b1, 1'b1, next_val, '0, 1'b0);
      next_val = next_val + SW'(1);
    end
    check("chunk2_pulse", 32'(chunk_pulse), 32'd1);
    check("chunk2_bank", 32'(rd_bank), 32'd1);
    for (int i = 0; i < 30; i++) begin
      tick(1'b1, 1'b1, next_val, (i == 0) ? PB'(0) : PB'(63), 1'b1);
      next_val = next_val + SW'(1);
      if (i == 0) check("pulse_cycle_read0", 32'(rd_sample), 32'd80);
      if (i == 1) check("read63", 32'(rd_sample), 32'd143);
    end
    check("fill_after_30", 32'(fill_level), 32'd30);

    // Drop enable mid-bank with a final strobe: abandoned, no pulse
    tick(1'b0, 1'b1, next_val, '0, 1'b0);
    check("drop_fill", 32'(fill_level), 32'd0);
    check("drop_bank", 32'(rd_bank), 32'd1);
    repeat (3) tick(1'b0, 1'b0, '0, '0, 1'b0);

    // Re-enable: 16 discards then 64 fresh samples
    tick(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < int'(DISC); i++) tick(1'b1, 1'b1, SW'(1000 + i), '0, 1'b0);
    for (int i = 0; i < int'(N); i++) tick(1'b1, 1'b1, SW'(2000 + i), '0, 1'b0);
    check("chunk3_pulse", 32'(chunk_pulse), 32'd1);
    check("chunk3_bank", 32'(rd_bank), 32'd0);
    tick(1'b1, 1'b0, '0, '0, 1'b1);
    check("chunk3_first", 32'(rd_sample), 32'd2000);
    tick(1'b1, 1'b0, '0, PB'(63), 1'b1);
    check("chunk3_last", 32'(rd_sample), 32'd2063);
`ifdef SAMPLE_CHUNKER_CHUNK_COUNT_EN
    check("chunk_count_3", 32'(chunk_count), 32'd3);
`endif

    // Async reset at wr_ptr=40, checked before any clock edge
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b1, SW'(3000 + i), '0, 1'b0);
    check("pre_reset_fill", 32'(fill_level), 32'd40);
    #2;
    rst = 1'b1;
    #1;
    check("async_pulse", 32'(chunk_pulse), 32'd0);
    check("async_rd_bank", 32'(rd_bank), 32'd1);
    check("async_fill", 32'(fill_level), 32'd0);
    check("async_rd_sample", 32'(rd_sample), 32'd0);
`ifdef SAMPLE_CHUNKER_CHUNK_COUNT_EN
    check("async_chunk_count", 32'(chunk_count), 32'd0);
`endif
    model_reset();
    enable   = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Post-reset chunk lands in bank 0 again
    tick(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < int'(DISC); i++) tick(1'b1, 1'b1, SW'(4000 + i), '0, 1'b0);
    for (int i = 0; i < int'(N); i++) tick(1'b1, 1'b1, SW'(5000 + i), '0, 1'b0);
    check("post_reset_bank", 32'(rd_bank), 32'd0);
    for (int p = 0; p < int'(N); p += 9) tick(1'b1, 1'b0, '0, PB'(p), 1'b1);
    tick(1'b1, 1'b0, '0, PB'(5), 1'b1);
    check("post_reset_read5", 32'(rd_sample), 32'd5005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
